// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - six-source interrupt controller with level/edge latching, mask and priority vector
module int_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [5:0]  irq_in,
  output logic [5:0]  HWInt,
  output logic        irq_any
);

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_MODE    = 2'd2;
  localparam logic [1:0] REG_VECTOR  = 2'd3;

  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] irq_dly_q;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] hwint_q;
  logic             irq_any_q;

  logic [N_SRC-1:0] active;
  logic             vec_valid;
  logic [2:0]       vec_idx;
  logic             wr_pending;

  assign active     = pending_q & mask_q;
  assign wr_pending = WE && (Addr[3:2] == REG_PENDING);

  // Pending next state: level bits follow the line, edge bits latch rising edges and clear on W1C (set wins)
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i]) begin
        pending_d[i] = (irq_in[i] & ~irq_dly_q[i]) |
                       (pending_q[i] & ~(wr_pending & Din[i]));
      end else begin
        pending_d[i] = irq_in[i];
      end
    end
  end

  // Mask and mode register writes
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (WE && (Addr[3:2] == REG_MASK)) mask_d = Din[N_SRC-1:0];
    if (WE && (Addr[3:2] == REG_MODE)) mode_d = Din[N_SRC-1:0];
  end

  // Priority encoder: lowest-numbered active source wins, idx is 0 when nothing is active
  always_comb begin
    vec_valid = |active;
    vec_idx   = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 3'(i);
    end
  end

  // Read mux, combinational from the current register state
  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      REG_PENDING: Dout = {26'd0, pending_q};
      REG_MASK:    Dout = {26'd0, mask_q};
      REG_MODE:    Dout = {26'd0, mode_q};
      REG_VECTOR:  Dout = {vec_valid, 28'd0, vec_idx};
      default:     Dout = 32'd0;
    endcase
  end

  // State and output registers; outputs use the pre-update pending and mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      irq_dly_q <= '0;
      mask_q    <= '1;
      mode_q    <= '0;
      hwint_q   <= '0;
      irq_any_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_dly_q <= irq_in;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      hwint_q   <= active;
      irq_any_q <= |active;
    end
  end

  assign HWInt   = hwint_q;
  assign irq_any = irq_any_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - scoreboard testbench for int_ctrl
module tb_int_ctrl;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [5:0]  irq_in;
  logic [5:0]  HWInt;
  logic        irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int SEL_DOUT = 0;
  localparam int SEL_HW   = 1;
  localparam int SEL_ANY  = 2;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  int_ctrl #(.N_SRC(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq_in  (irq_in),
    .HWInt   (HWInt),
    .irq_any (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: at each falling edge, compare every queued expectation with the DUT outputs
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          SEL_DOUT: act = Dout;
          SEL_HW:   act = {26'd0, HWInt};
          default:  act = {31'd0, irq_any};
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic chk_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    Addr  = {28'd0, a};
    e.sel = SEL_DOUT;
    e.exp = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic chk_hw(input logic [5:0] exp, input string name);
    exp_t e;
    e.sel = SEL_HW;
    e.exp = {26'd0, exp};
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic chk_any(input logic exp, input string name);
    exp_t e;
    e.sel = SEL_ANY;
    e.exp = {31'd0, exp};
    e.name = name;
    sb_q.push_back(e);
  endtask

  initial begin
    reset  = 1'b1;
    Addr   = '0;
    WE     = 1'b0;
    Din    = '0;
    irq_in = 6'b001000;

    // Reset state and pass-through
    tick(); tick();
    chk_rd(2'd1, 32'h3F, "rst_mask");
    chk_hw(6'h00, "rst_hwint");
    chk_any(1'b0, "rst_any");
    settle();
    chk_rd(2'd2, 32'h00, "rst_mode");
    settle();
    reset = 1'b0;
    tick();
    chk_rd(2'd0, 32'h08, "pt_pending_e1");
    chk_hw(6'h00, "pt_hwint_e1");
    settle();
    tick();
    chk_hw(6'h08, "pt_hwint_e2");
    chk_any(1'b1, "pt_any_e2");
    settle();
    irq_in = 6'h00;
    tick();
    chk_hw(6'h08, "pt_drop_e1");
    settle();
    tick();
    chk_hw(6'h00, "pt_drop_e2");
    chk_any(1'b0, "pt_drop_any");
    settle();

    // Edge latch and W1C
    wr(2'd2, 32'h04);
    irq_in = 6'h04;
    tick();
    irq_in = 6'h00;
    chk_rd(2'd0, 32'h04, "edge_pending");
    settle();
    tick();
    chk_rd(2'd0, 32'h04, "edge_pending_hold");
    chk_hw(6'h04, "edge_hwint");
    settle();
    wr(2'd0, 32'h04);
    chk_rd(2'd0, 32'h00, "w1c_pending");
    chk_hw(6'h04, "w1c_hwint_e1");
    settle();
    tick();
    chk_hw(6'h00, "w1c_hwint_e2");
    settle();

    // Set/clear collision: set wins
    wr(2'd2, 32'h0C);
    irq_in = 6'h08;
    wr(2'd0, 32'h08);
    irq_in = 6'h00;
    chk_rd(2'd0, 32'h08, "collide_pending");
    settle();
    wr(2'd0, 32'h08);
    chk_rd(2'd0, 32'h00, "collide_clear");
    settle();

    // W1C on a level-mode bit is ignored
    irq_in = 6'h01;
    tick();
    wr(2'd0, 32'h01);
    chk_rd(2'd0, 32'h01, "level_w1c_ignored");
    settle();
    irq_in = 6'h00;
    tick();
    chk_rd(2'd0, 32'h00, "level_follow_low");
    settle();

    // Masking does not gate latching
    wr(2'd1, 32'h00);
    wr(2'd2, 32'h3F);
    irq_in = 6'h10;
    tick();
    irq_in = 6'h00;
    tick();
    chk_rd(2'd0, 32'h10, "mask_pending");
    chk_hw(6'h00, "mask_hwint");
    chk_any(1'b0, "mask_any");
    settle();
    tick();
    chk_rd(2'd3, 32'h00000000, "mask_vector");
    settle();
    wr(2'd1, 32'h10);
    chk_rd(2'd3, 32'h80000004, "unmask_vector");
    settle();
    tick();
    chk_hw(6'h10, "unmask_hwint");
    chk_any(1'b1, "unmask_any");
    settle();

    // Priority
    wr(2'd0, 32'h10);
    wr(2'd1, 32'h3F);
    irq_in = 6'h2C;
    tick();
    irq_in = 6'h00;
    tick();
    chk_rd(2'd0, 32'h2C, "prio_pending");
    settle();
    tick();
    chk_rd(2'd3, 32'h80000002, "prio_vector_2");
    settle();
    wr(2'd0, 32'h04);
    chk_rd(2'd3, 32'h80000003, "prio_vector_3");
    settle();
    tick();
    chk_hw(6'h28, "prio_hwint");
    settle();

    // Asynchronous reset mid-operation
    wr(2'd0, 32'h3F);
    irq_in = 6'h3C;
    tick();
    irq_in = 6'h00;
    tick();
    tick();
    chk_rd(2'd0, 32'h3C, "pre_rst_pending");
    chk_hw(6'h3C, "pre_rst_hwint");
    settle();
    tick();
    reset = 1'b1;
    chk_rd(2'd0, 32'h00, "async_rst_pending");
    chk_hw(6'h00, "async_rst_hwint");
    chk_any(1'b0, "async_rst_any");
    settle();
    tick();
    reset = 1'b0;
    chk_rd(2'd1, 32'h3F, "post_rst_mask");
    settle();
    tick();
    chk_rd(2'd2, 32'h00, "post_rst_mode");
    settle();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
